// File: rtl/note_timer_pkg.sv
// Shared types, defaults and phase-length arithmetic for the note duration timer.
// Loop support (NOTE_TIMER_LOOP_EN) is handled in the top; nothing here depends on it.
package note_timer_pkg;

   localparam int DUR_W_DEF = 8;
   localparam int GAP_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GATE = 2'd1,
      GAP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] gateLen;
      logic [31:0] gapLen;
   } phase_t;

   // A gap that swallows the whole note still leaves a one-tick gate.
   function automatic phase_t calcPhase(input logic [31:0] dur, input logic [31:0] gap);
      phase_t p;
      p.gateLen = (gap >= dur) ? 32'd1 : dur - gap;
      p.gapLen  = dur - p.gateLen;
      return p;
   endfunction

endpackage

// File: rtl/note_timer_if.sv
// Sequencer-to-voice bundle for the note timer; i_loop only exists when
// NOTE_TIMER_LOOP_EN is defined.
interface note_timer_if
   import note_timer_pkg::*;
#(
   parameter int DUR_W = DUR_W_DEF,
   parameter int GAP_W = GAP_W_DEF
) ();

   logic             i_enable;
   logic             i_hold;
   logic             i_load;
   logic [DUR_W-1:0] i_duration;
   logic [GAP_W-1:0] i_gap;
`ifdef NOTE_TIMER_LOOP_EN
   logic             i_loop;
`endif
   logic             o_gate;
   logic             o_running;
   logic             o_done;
   logic [DUR_W-1:0] o_remaining;

`ifdef NOTE_TIMER_LOOP_EN
   modport master (output i_enable, i_hold, i_load, i_duration, i_gap, i_loop,
                   input  o_gate, o_running, o_done, o_remaining);
   modport slave  (input  i_enable, i_hold, i_load, i_duration, i_gap, i_loop,
                   output o_gate, o_running, o_done, o_remaining);
`else
   modport master (output i_enable, i_hold, i_load, i_duration, i_gap,
                   input  o_gate, o_running, o_done, o_remaining);
   modport slave  (input  i_enable, i_hold, i_load, i_duration, i_gap,
                   output o_gate, o_running, o_done, o_remaining);
`endif

endinterface

// File: rtl/note_timer_tick_down_counter.sv
// Loadable down-counter; load has priority over tick, and at_one flags the last tick.
module tick_down_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         load_i,
   input  logic [W-1:0] loadVal_i,
   input  logic         tick_i,
   output logic [W-1:0] count_o,
   output logic         atOne_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadVal_i;
      end else if (tick_i) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign atOne_o = (count_q == W'(1));

endmodule

// File: rtl/note_timer.sv
// Note-duration timer: gate phase then articulation gap, with retrigger, hold and abort.
// Defining NOTE_TIMER_LOOP_EN adds i_loop and latched auto-repeat of the last note.
module note_timer
   import note_timer_pkg::*;
#(
   parameter int DUR_W = DUR_W_DEF,
   parameter int GAP_W = GAP_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   note_timer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [DUR_W-1:0] gapLen_q, gapLen_d;
   logic             done_q, done_d;
`ifdef NOTE_TIMER_LOOP_EN
   logic [DUR_W-1:0] gateLen_q, gateLen_d;
   logic             loop_q, loop_d;
`endif

   logic [GAP_W-1:0] gapIn;
   phase_t           phase;
   logic [DUR_W-1:0] newGate, newGap;
   logic             unusedPhaseHi;
   logic             cntLoad, cntTick, atOne, tick;
   logic [DUR_W-1:0] cntLoadVal, count;

   assign gapIn         = bus.i_gap;
   assign phase         = calcPhase(32'(bus.i_duration), 32'(gapIn));
   assign newGate       = phase.gateLen[DUR_W-1:0];
   assign newGap        = phase.gapLen[DUR_W-1:0];
   assign unusedPhaseHi = ^{phase.gateLen[31:DUR_W], phase.gapLen[31:DUR_W]};
   assign tick          = bus.i_enable && !bus.i_hold && !bus.i_load;

   tick_down_counter #(.W(DUR_W)) u_counter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .load_i    (cntLoad),
      .loadVal_i (cntLoadVal),
      .tick_i    (cntTick),
      .count_o   (count),
      .atOne_o   (atOne)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         gapLen_q  <= '0;
         done_q    <= 1'b0;
`ifdef NOTE_TIMER_LOOP_EN
         gateLen_q <= '0;
         loop_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gapLen_q  <= gapLen_d;
         done_q    <= done_d;
`ifdef NOTE_TIMER_LOOP_EN
         gateLen_q <= gateLen_d;
         loop_q    <= loop_d;
`endif
      end
   end

   // A load always beats a coincident tick, so a retrigger on the final tick never reports done.
   always_comb begin
      state_d    = state_q;
      gapLen_d   = gapLen_q;
      done_d     = 1'b0;
      cntLoad    = 1'b0;
      cntLoadVal = '0;
      cntTick    = 1'b0;
`ifdef NOTE_TIMER_LOOP_EN
      gateLen_d  = gateLen_q;
      loop_d     = loop_q;
`endif
      if (bus.i_load) begin
         if (bus.i_duration != '0) begin
            state_d    = GATE;
            gapLen_d   = newGap;
            cntLoad    = 1'b1;
            cntLoadVal = newGate;
`ifdef NOTE_TIMER_LOOP_EN
            gateLen_d  = newGate;
            loop_d     = bus.i_loop;
`endif
         end else if (state_q != IDLE) begin
            state_d = IDLE;
            cntLoad = 1'b1;
`ifdef NOTE_TIMER_LOOP_EN
            loop_d  = 1'b0;
`endif
         end
      end else if (tick && state_q != IDLE) begin
         if (!atOne) begin
            cntTick = 1'b1;
         end else if (state_q == GATE && gapLen_q != '0) begin
            state_d    = GAP;
            cntLoad    = 1'b1;
            cntLoadVal = gapLen_q;
         end else begin
            done_d  = 1'b1;
            cntLoad = 1'b1;
`ifdef NOTE_TIMER_LOOP_EN
            if (loop_q) begin
               state_d    = GATE;
               cntLoadVal = gateLen_q;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
      end
   end

   always_comb begin
      bus.o_gate      = (state_q == GATE);
      bus.o_running   = (state_q != IDLE);
      bus.o_done      = done_q;
      bus.o_remaining = '0;
      case (state_q)
         GATE:    bus.o_remaining = count + gapLen_q;
         GAP:     bus.o_remaining = count;
         default: bus.o_remaining = '0;
      endcase
   end

endmodule
